// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: power-on hold, debounced button and software
// reset, staged per-channel release (channel 0 first) and last-cause reporting.
module reset_sequencer #(
  parameter int NUM_CH          = 4,
  parameter int CNT_WIDTH       = 8,
  parameter int POR_CYCLES      = 7,
  parameter int HOLD_CYCLES     = 7,
  parameter int STAGE_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_rst_button,
  input  logic              i_sw_rst,
  output logic [NUM_CH-1:0] o_rst,
  output logic              o_ready,
  output logic [1:0]        o_cause
);

  localparam int STAGE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] POR_LOAD   = CNT_WIDTH'(POR_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD  = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] STAGE_LOAD = CNT_WIDTH'(STAGE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [STAGE_W-1:0]   STAGE_ONE  = STAGE_W'(1);
  localparam logic [STAGE_W-1:0]   LAST_STAGE = STAGE_W'(NUM_CH - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {POR, HOLD, RELEASE, RUN} state_t;

  logic                 btn_meta = 1'b0;
  logic                 btn_sync = 1'b0;
  logic                 btn_db   = 1'b0;
  logic                 btn_rise = 1'b0;
  logic [CNT_WIDTH-1:0] db_cnt   = '0;

  state_t               state    = POR;
  logic [CNT_WIDTH-1:0] cnt      = POR_LOAD;
  logic [STAGE_W-1:0]   stage    = '0;
  logic [NUM_CH-1:0]    rst_q    = '1;
  logic                 ready_q  = 1'b0;
  logic [1:0]           cause_q  = CAUSE_POR;

  // The synchroniser is deliberately left out of i_rst so the button is
  // still tracked while the rest of the block is held in reset.
  always_ff @(posedge clk) begin
    btn_meta <= i_rst_button;
    btn_sync <= btn_meta;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      btn_db   <= 1'b0;
      db_cnt   <= '0;
      btn_rise <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        btn_db   <= btn_sync;
        db_cnt   <= '0;
        btn_rise <= btn_sync;
      end else begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end
  end

  // btn_rise is a one-cycle pulse on the debounced press, so a button held
  // through RUN cannot retrigger until it has been released and pressed again.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= POR;
      cnt     <= POR_LOAD;
      stage   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      unique case (state)
        POR, HOLD: begin
          rst_q   <= '1;
          ready_q <= 1'b0;
          if (state == HOLD && btn_db) begin
            cnt <= HOLD_LOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (!btn_db) begin
            state <= RELEASE;
            cnt   <= STAGE_LOAD;
            stage <= '0;
          end
        end
        RELEASE, RUN: begin
          if (btn_rise || i_sw_rst) begin
            state   <= HOLD;
            cnt     <= HOLD_LOAD;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= btn_rise ? CAUSE_BTN : CAUSE_SW;
          end else if (state == RELEASE) begin
            if (cnt <= CNT_ONE) begin
              rst_q[stage] <= 1'b0;
              cnt          <= STAGE_LOAD;
              if (stage == LAST_STAGE) begin
                state   <= RUN;
                ready_q <= 1'b1;
              end else begin
                stage <= stage + STAGE_ONE;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end else begin
            rst_q   <= '0;
            ready_q <= 1'b1;
          end
        end
        default: state <= POR;
      endcase
    end
  end

  assign o_rst   = rst_q;
  assign o_ready = ready_q;
  assign o_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timestamp-based reference model
// predicts every cycle's outputs, and a negedge monitor compares them.
module tb_reset_sequencer;

  localparam int NUM_CH          = 4;
  localparam int CNT_WIDTH       = 8;
  localparam int POR_CYCLES      = 7;
  localparam int HOLD_CYCLES     = 7;
  localparam int STAGE_CYCLES    = 4;
  localparam int DEBOUNCE_CYCLES = 3;
  localparam int MAX_EDGES       = 8192;

  localparam int P_POR  = 0;
  localparam int P_HOLD = 1;
  localparam int P_REL  = 2;
  localparam int P_RUN  = 3;

  logic              clk          = 1'b0;
  logic              i_rst        = 1'b1;
  logic              i_rst_button = 1'b0;
  logic              i_sw_rst     = 1'b0;
  logic [NUM_CH-1:0] o_rst;
  logic              o_ready;
  logic [1:0]        o_cause;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] rst;
    logic              ready;
    logic [1:0]        cause;
  } exp_t;

  exp_t exp_q[$];

  reset_sequencer #(
    .NUM_CH(NUM_CH),
    .CNT_WIDTH(CNT_WIDTH),
    .POR_CYCLES(POR_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .STAGE_CYCLES(STAGE_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk),
    .i_rst(i_rst),
    .i_rst_button(i_rst_button),
    .i_sw_rst(i_sw_rst),
    .o_rst(o_rst),
    .o_ready(o_ready),
    .o_cause(o_cause)
  );

  always #5 clk = ~clk;

  // Reference model state: raw button samples and debounced level per edge,
  // plus the current phase and the edge that phase's timing is measured from.
  bit raw_s [0:MAX_EDGES-1];
  bit db_h  [0:MAX_EDGES-1];
  int n       = 0;
  int dstart  = 0;
  int phase   = P_POR;
  int t0      = 0;
  int m_cause = 0;

  function automatic bit synced_at(input int edge_idx);
    int k;
    k = edge_idx - 2;
    return (k >= 1) ? raw_s[k] : 1'b0;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    bit   pdb;
    bit   rise;
    bit   all_diff;
    n = n + 1;
    if (n >= MAX_EDGES - 1) begin
      $display("[TB] FAIL model_capacity: edge %0d exceeds model history %0d", n, MAX_EDGES);
      $fatal(1, "[TB] model history exhausted");
    end
    raw_s[n] = i_rst_button;
    pdb  = db_h[n-1];
    rise = (n >= 2) && db_h[n-1] && !db_h[n-2];

    db_h[n] = db_h[n-1];
    if (i_rst) begin
      db_h[n] = 1'b0;
      dstart  = n;
    end else if (n - dstart >= DEBOUNCE_CYCLES) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEBOUNCE_CYCLES; j++)
        if (synced_at(n - j) == db_h[n-1]) all_diff = 1'b0;
      if (all_diff) begin
        db_h[n] = !db_h[n-1];
        dstart  = n;
      end
    end

    if (i_rst) begin
      phase   = P_POR;
      t0      = n;
      m_cause = 0;
    end else begin
      case (phase)
        P_POR: begin
          if ((n - t0 > POR_CYCLES) && !pdb) begin
            phase = P_REL;
            t0    = n;
          end
        end
        P_HOLD: begin
          if (pdb) t0 = n;
          else if (n - t0 > HOLD_CYCLES) begin
            phase = P_REL;
            t0    = n;
          end
        end
        default: begin
          if (rise || i_sw_rst) begin
            m_cause = rise ? 1 : 2;
            phase   = P_HOLD;
            t0      = n;
          end else if (phase == P_REL && (n - t0 >= STAGE_CYCLES * NUM_CH)) begin
            phase = P_RUN;
          end
        end
      endcase
    end

    e.cause = 2'(m_cause);
    e.ready = 1'b0;
    e.rst   = '1;
    if (phase == P_REL) begin
      for (int c = 0; c < NUM_CH; c++)
        e.rst[c] = !((n - t0) >= STAGE_CYCLES * (c + 1));
    end else if (phase == P_RUN) begin
      e.rst   = '0;
      e.ready = 1'b1;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({o_rst, o_ready, o_cause} !== e) begin
        errors++;
        $display("[TB] FAIL cycle_%0d: got o_rst=%b o_ready=%b o_cause=%b, expected o_rst=%b o_ready=%b o_cause=%b",
                 n, o_rst, o_ready, o_cause, e.rst, e.ready, e.cause);
      end
    end
  end

  task automatic applyStimulus(input bit rst, input bit btn, input bit sw, input int cycles);
    i_rst        = rst;
    i_rst_button = btn;
    i_sw_rst     = sw;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [NUM_CH-1:0] er,
                             input logic eready, input logic [1:0] ecause);
    checks++;
    if (o_rst !== er || o_ready !== eready || o_cause !== ecause) begin
      errors++;
      $display("[TB] FAIL %s: got o_rst=%b o_ready=%b o_cause=%b, expected o_rst=%b o_ready=%b o_cause=%b",
               name, o_rst, o_ready, o_cause, er, eready, ecause);
    end
  endtask

  initial begin : stimulus
    logic [NUM_CH-1:0] full;
    int                rel;
    bit                found;
    bit                btn;
    int                len;
    full = '1;

    $display("[TB] power-on sequence");
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    for (int j = 1; j <= 26; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      rel = (j >= 12) ? (j - 8) / 4 : 0;
      if (j == 11 || j == 12 || j == 16 || j == 20 || j == 24)
        checkOutput($sformatf("por_edge_%0d", j), full << rel, (j >= 24), 2'b00);
    end

    $display("[TB] button press in RUN");
    applyStimulus(1'b0, 1'b1, 1'b0, 6);
    checkOutput("button_latency", full, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 14);
    applyStimulus(1'b0, 1'b0, 1'b0, 40);
    checkOutput("button_rerun", '0, 1'b1, 2'b01);

    $display("[TB] glitch rejection");
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("glitch_ignored", '0, 1'b1, 2'b01);

    $display("[TB] software reset mid-release");
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      if (o_rst === 4'b1100) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_1100: got o_rst=%b, required 1100 within 40 cycles", o_rst);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("sw_mid_release", full, 1'b0, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b0, 40);
    checkOutput("sw_rerun", '0, 1'b1, 2'b10);

    $display("[TB] simultaneous triggers");
    applyStimulus(1'b0, 1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("button_wins", full, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 40);

    $display("[TB] software reset ignored during POR");
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    for (int j = 1; j <= 26; j++) begin
      applyStimulus(1'b0, 1'b0, (j % 2 == 1) && (j <= 7), 1);
      rel = (j >= 12) ? (j - 8) / 4 : 0;
      if (j == 12 || j == 24)
        checkOutput($sformatf("por_sw_edge_%0d", j), full << rel, (j >= 24), 2'b00);
    end

    $display("[TB] i_rst mid-HOLD with button held");
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("rst_in_hold", full, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 30);
    checkOutput("por_button_held", full, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b0, 40);
    checkOutput("por_after_release", '0, 1'b1, 2'b00);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 60; it++) begin
      btn = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int c = 0; c < len; c++)
        applyStimulus(($urandom_range(0, 79) == 0), btn, ($urandom_range(0, 11) == 0), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
